// File: rtl/usb4_lane_descrambler_if.sv
// Receive-side bus for the USB4 lane descrambler.
// Lanes are packed side by side, with lane l at [l*DATA_W +: DATA_W].
// The master drives beats in. The slave (the descrambler) returns the registered results.
interface usb4_lane_descrambler_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic                      in_valid;
    logic [LANES*DATA_W-1:0]   in_data;
    logic [LANES-1:0]          in_hold;
    logic [LANES-1:0]          scr_rst;
    logic                      bypass;
    logic                      chk_en;
    logic                      chk_clr;
    logic                      out_valid;
    logic [LANES*DATA_W-1:0]   out_data;
    logic [LANES-1:0]          lane_seeded;
    logic [LANES*CNT_W-1:0]    err_cnt;

    modport master (
        output in_valid, in_data, in_hold, scr_rst, bypass, chk_en, chk_clr,
        input  out_valid, out_data, lane_seeded, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_hold, scr_rst, bypass, chk_en, chk_clr,
        output out_valid, out_data, lane_seeded, err_cnt
    );
endinterface

// File: rtl/usb4_lane_descrambler.sv
// Multi-lane, parallel-word additive descrambler for the USB4 logical-layer receive path.
// Each lane owns one Galois LFSR register. The DATA_W-step unrolling of that LFSR is
// purely combinational. A beat is descrambled from the lane's current (or reseeded)
// state, and the result is registered with a latency of one cycle.
// A per-lane saturating counter tracks non-zero descrambled words while PRBS checking is enabled.
module usb4_lane_descrambler #(
    parameter int                LANES  = 2,
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 23,
    parameter logic [LFSR_W-1:0] POLY   = 23'h210125,
    parameter logic [LFSR_W-1:0] SEED   = 23'h1DBFBC,
    parameter int                CNT_W  = 16
) (
    input logic                     clk,
    input logic                     rst,
    usb4_lane_descrambler_if.slave  bus
);

    // Single Galois step: shift left, fold the polynomial back in when the msb falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? POLY : '0);
    endfunction

    // Keystream for one beat: bit i is the msb seen before step i.
    function automatic logic [DATA_W-1:0] key_word(input logic [LFSR_W-1:0] s0);
        logic [LFSR_W-1:0] s;
        key_word = '0;
        s        = s0;
        for (int i = 0; i < DATA_W; i++) begin
            key_word[i] = s[LFSR_W-1];
            s           = lfsr_step(s);
        end
    endfunction

    // State after DATA_W steps from s0.
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s0);
        lfsr_advance = s0;
        for (int i = 0; i < DATA_W; i++) begin
            lfsr_advance = lfsr_step(lfsr_advance);
        end
    endfunction

    // Saturating increment: sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        sat_inc = (inc && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    logic [LFSR_W-1:0] lfsr_state [LANES];

    // stage p0: combinational beat processing from lane state and inputs
    logic [LFSR_W-1:0] start_p0 [LANES];
    logic [LFSR_W-1:0] next_p0  [LANES];
    logic [DATA_W-1:0] din_p0   [LANES];
    logic [DATA_W-1:0] desc_p0  [LANES];
    logic [DATA_W-1:0] word_p0  [LANES];
    logic [CNT_W-1:0]  cnt_p0   [LANES];
    logic [LANES-1:0]  live_p0;
    logic [LANES-1:0]  err_p0;

    // stage p1: registered outputs
    logic [DATA_W-1:0] data_p1  [LANES];
    logic [CNT_W-1:0]  cnt_p1   [LANES];
    logic              vld_p1;
    logic [LANES-1:0]  seeded_p1;

    // Per-lane descramble, next-state and error-count selection.
    always_comb begin
        live_p0 = '0;
        err_p0  = '0;
        for (int l = 0; l < LANES; l++) begin
            din_p0[l]   = bus.in_data[l*DATA_W +: DATA_W];
            // A reload takes effect for the beat in the same cycle.
            start_p0[l] = bus.scr_rst[l] ? SEED : lfsr_state[l];
            desc_p0[l]  = din_p0[l] ^ key_word(start_p0[l]);
            live_p0[l]  = bus.in_valid && !bus.in_hold[l];
            word_p0[l]  = (bus.bypass || bus.in_hold[l]) ? din_p0[l] : desc_p0[l];
            // Bypass does not freeze the LFSR. Only hold or a missing beat freezes it.
            next_p0[l]  = live_p0[l] ? lfsr_advance(start_p0[l]) : start_p0[l];
            err_p0[l]   = bus.chk_en && live_p0[l] && !bus.bypass && (desc_p0[l] != '0);
            // A clear wins over an increment in the same cycle.
            cnt_p0[l]   = bus.chk_clr ? '0 : sat_inc(cnt_p1[l], err_p0[l]);
        end
    end

    // LFSR state per lane. Reset puts every lane at SEED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                lfsr_state[l] <= SEED;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                lfsr_state[l] <= next_p0[l];
            end
        end
    end

    // Output word register. It only loads on valid beats, so it holds between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                data_p1[l] <= '0;
            end
        end else if (bus.in_valid) begin
            for (int l = 0; l < LANES; l++) begin
                data_p1[l] <= word_p0[l];
            end
        end
    end

    // Valid flag, seeded flags and error counters. They update on the same edge as the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            seeded_p1 <= '0;
            for (int l = 0; l < LANES; l++) begin
                cnt_p1[l] <= '0;
            end
        end else begin
            vld_p1    <= bus.in_valid;
            seeded_p1 <= seeded_p1 | bus.scr_rst;
            for (int l = 0; l < LANES; l++) begin
                cnt_p1[l] <= cnt_p0[l];
            end
        end
    end

    // Pack per-lane registers onto the flat output buses.
    always_comb begin
        bus.out_data = '0;
        bus.err_cnt  = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.out_data[l*DATA_W +: DATA_W] = data_p1[l];
            bus.err_cnt[l*CNT_W +: CNT_W]    = cnt_p1[l];
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.lane_seeded = seeded_p1;

endmodule

// File: tb/tb_usb4_lane_descrambler.sv
// Bench for usb4_lane_descrambler.
// dut_a is a small 4-bit LFSR instance with a 2-bit counter. Its keystream is short
// enough to check against hand-derived words.
// dut_b uses the default USB4 parameters with two lanes.
// The reference model tracks each lane as a position in a precomputed keystream bit sequence.
module tb_usb4_lane_descrambler;

    localparam int KS_A_LEN = 15;
    localparam int KS_B_LEN = 16384;
    localparam int CNT_A    = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    usb4_lane_descrambler_if #(.LANES(1), .DATA_W(8), .CNT_W(CNT_A)) bus_a ();
    usb4_lane_descrambler_if #(.LANES(2), .DATA_W(8), .CNT_W(16))    bus_b ();

    usb4_lane_descrambler #(
        .LANES(1), .DATA_W(8), .LFSR_W(4), .POLY(4'h3), .SEED(4'h1), .CNT_W(CNT_A)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    usb4_lane_descrambler #(
        .LANES(2), .DATA_W(8), .LFSR_W(23), .POLY(23'h210125), .SEED(23'h1DBFBC), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // Keystream bit sequences counted from SEED.
    bit ks_a [KS_A_LEN];
    bit ks_b [KS_B_LEN];

    // Model state. Lane index 0 is dut_a, and indices 1 and 2 are dut_b lanes 0 and 1.
    int         mpos   [3];
    bit         mseed  [3];
    int         mcnt   [3];
    logic [7:0] mout   [3];
    bit         mvld_a;
    bit         mvld_b;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit key(input int which, input int idx);
        if (which == 0) return ks_a[idx % KS_A_LEN];
        if (idx < KS_B_LEN) return ks_b[idx];
        return 1'b0;
    endfunction

    function automatic logic [7:0] key_word(input int which, input int pos);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = key(which, pos + i);
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            mpos[g] = 0; mseed[g] = 0; mcnt[g] = 0; mout[g] = 8'h00;
        end
        mvld_a = 0;
        mvld_b = 0;
    endtask

    task automatic model_lane(input int g, input int which, input bit valid, input bit hold,
                              input bit srst, input bit byp, input bit chk, input bit clr,
                              input logic [7:0] din, input int maxc);
        int         p;
        logic [7:0] w;
        bit         err;
        err = 0;
        p   = srst ? 0 : mpos[g];
        if (srst) mseed[g] = 1;
        if (valid) begin
            for (int i = 0; i < 8; i++) w[i] = din[i] ^ key(which, p + i);
            if (hold) begin
                mout[g] = din;
            end else begin
                mout[g] = byp ? din : w;
                err     = chk && !byp && (w != 8'h00);
                p       = p + 8;
            end
        end
        mpos[g] = (which == 0) ? (p % KS_A_LEN) : p;
        if (clr) mcnt[g] = 0;
        else if (err && mcnt[g] < maxc) mcnt[g] = mcnt[g] + 1;
    endtask

    task automatic model_all();
        mvld_a = bus_a.in_valid;
        mvld_b = bus_b.in_valid;
        model_lane(0, 0, bus_a.in_valid, bus_a.in_hold[0], bus_a.scr_rst[0], bus_a.bypass,
                   bus_a.chk_en, bus_a.chk_clr, bus_a.in_data, (1 << CNT_A) - 1);
        for (int l = 0; l < 2; l++)
            model_lane(1 + l, 1, bus_b.in_valid, bus_b.in_hold[l], bus_b.scr_rst[l], bus_b.bypass,
                       bus_b.chk_en, bus_b.chk_clr, bus_b.in_data[l*8 +: 8], 65535);
    endtask

    task automatic compare_all();
        check("a_valid",  32'(bus_a.out_valid),   32'(mvld_a));
        check("a_data",   32'(bus_a.out_data),    32'(mout[0]));
        check("a_errcnt", 32'(bus_a.err_cnt),     32'(mcnt[0]));
        check("a_seeded", 32'(bus_a.lane_seeded), 32'(mseed[0]));
        check("b_valid",  32'(bus_b.out_valid),   32'(mvld_b));
        check("b_data",   32'(bus_b.out_data),    32'({mout[2], mout[1]}));
        check("b_errcnt", bus_b.err_cnt,          {16'(mcnt[2]), 16'(mcnt[1])});
        check("b_seeded", 32'(bus_b.lane_seeded), 32'({mseed[2], mseed[1]}));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_all();
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_a();
        bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.in_hold = '0; bus_a.scr_rst = '0;
        bus_a.bypass = 0; bus_a.chk_en = 0; bus_a.chk_clr = 0;
    endtask

    task automatic idle_b();
        bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.in_hold = '0; bus_b.scr_rst = '0;
        bus_b.bypass = 0; bus_b.chk_en = 0; bus_b.chk_clr = 0;
    endtask

    task automatic rand_a();
        bus_a.in_valid = ($urandom_range(0, 3) != 0);
        bus_a.in_hold  = 1'($urandom_range(0, 5) == 0);
        bus_a.scr_rst  = 1'($urandom_range(0, 9) == 0);
        bus_a.bypass   = ($urandom_range(0, 7) == 0);
        bus_a.chk_en   = 1'($urandom_range(0, 1));
        bus_a.chk_clr  = ($urandom_range(0, 15) == 0);
        bus_a.in_data  = ($urandom_range(0, 2) == 0)
                       ? key_word(0, bus_a.scr_rst[0] ? 0 : mpos[0]) : 8'($urandom);
    endtask

    task automatic rand_b();
        bus_b.in_valid = ($urandom_range(0, 3) != 0);
        bus_b.bypass   = ($urandom_range(0, 7) == 0);
        bus_b.chk_en   = 1'($urandom_range(0, 1));
        bus_b.chk_clr  = ($urandom_range(0, 31) == 0);
        for (int l = 0; l < 2; l++) begin
            bus_b.in_hold[l]      = ($urandom_range(0, 5) == 0);
            bus_b.scr_rst[l]      = ($urandom_range(0, 15) == 0);
            bus_b.in_data[l*8 +: 8] = ($urandom_range(0, 2) == 0)
                ? key_word(1, bus_b.scr_rst[l] ? 0 : mpos[1 + l]) : 8'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  sa;
        logic [22:0] sb;
        logic [15:0] byp_in;
        sa = 4'h1;
        for (int k = 0; k < KS_A_LEN; k++) begin
            ks_a[k] = sa[3];
            sa = {sa[2:0], 1'b0} ^ (sa[3] ? 4'h3 : 4'h0);
        end
        sb = 23'h1DBFBC;
        for (int k = 0; k < KS_B_LEN; k++) begin
            ks_b[k] = sb[22];
            sb = {sb[21:0], 1'b0} ^ (sb[22] ? 23'h210125 : 23'h0);
        end

        rst = 1'b1;
        idle_a();
        idle_b();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Two zero beats from SEED; output lags the input by one cycle
        bus_a.in_valid = 1; bus_a.in_data = 8'h00;
        #1 check("a_latency", 32'(bus_a.out_valid), 32'd0);
        step(); check("a_zero1", 32'(bus_a.out_data), 32'hC8);
        step(); check("a_zero2", 32'(bus_a.out_data), 32'h7A);
        bus_a.in_valid = 0;
        step(); check("a_hold_last", 32'(bus_a.out_data), 32'h7A);

        // 15-beat period returns to SEED
        bus_a.in_valid = 1;
        repeat (13) step();
        step(); check("a_period", 32'(bus_a.out_data), 32'hC8);

        // Reload with a beat in the same cycle
        check("a_seed_before", 32'(bus_a.lane_seeded), 32'd0);
        bus_a.scr_rst = 1'b1;
        step(); check("a_reload", 32'(bus_a.out_data), 32'hC8);
        check("a_seed_after", 32'(bus_a.lane_seeded), 32'd1);
        bus_a.scr_rst = 1'b0;
        step(); check("a_after_reload", 32'(bus_a.out_data), 32'h7A);

        // PRBS check on exact scrambled zeros, then one flipped bit
        bus_a.in_valid = 0; bus_a.scr_rst = 1'b1; step(); bus_a.scr_rst = 1'b0;
        bus_a.chk_en = 1; bus_a.in_valid = 1;
        bus_a.in_data = 8'hC8; step(); check("a_chk1", 32'(bus_a.out_data), 32'h00);
        bus_a.in_data = 8'h7A; step(); check("a_chk2", 32'(bus_a.out_data), 32'h00);
        check("a_chk_cnt0", 32'(bus_a.err_cnt), 32'd0);
        bus_a.in_valid = 0; bus_a.scr_rst = 1'b1; step(); bus_a.scr_rst = 1'b0;
        bus_a.in_valid = 1;
        bus_a.in_data = 8'hC8; step();
        bus_a.in_data = 8'h72; step(); check("a_flip", 32'(bus_a.out_data), 32'h08);
        check("a_flip_cnt", 32'(bus_a.err_cnt), 32'd1);

        // Held beat passes through and freezes the LFSR
        bus_a.chk_en = 0;
        bus_a.in_valid = 0; bus_a.scr_rst = 1'b1; step(); bus_a.scr_rst = 1'b0;
        bus_a.in_valid = 1;
        bus_a.in_data = 8'h00; step(); check("a_h1", 32'(bus_a.out_data), 32'hC8);
        bus_a.in_data = 8'h55; bus_a.in_hold = 1'b1;
        step(); check("a_h2", 32'(bus_a.out_data), 32'h55);
        bus_a.in_data = 8'h00; bus_a.in_hold = 1'b0;
        step(); check("a_h3", 32'(bus_a.out_data), 32'h7A);

        // Counter saturation, then clear beats a same-cycle error
        bus_a.chk_en = 1;
        for (int k = 0; k < 5; k++) begin
            bus_a.in_data = key_word(0, mpos[0]) ^ 8'($urandom_range(1, 255));
            step();
        end
        check("a_saturate", 32'(bus_a.err_cnt), 32'd3);
        bus_a.in_data = key_word(0, mpos[0]) ^ 8'h01; bus_a.chk_clr = 1;
        step(); check("a_clear", 32'(bus_a.err_cnt), 32'd0);
        idle_a();

        // Random traffic on dut_a
        for (int k = 0; k < 200; k++) begin
            rand_a();
            step();
        end
        idle_a();

        // dut_b: two lanes stream, lane 0 reseeds mid-stream, then one bypass beat
        bus_b.in_valid = 1;
        for (int k = 0; k < 20; k++) begin
            bus_b.in_data = 16'($urandom);
            bus_b.scr_rst = (k == 10) ? 2'b01 : 2'b00;
            bus_b.bypass  = (k == 15);
            byp_in = bus_b.in_data;
            step();
            if (k == 15) check("b_bypass", 32'(bus_b.out_data), 32'(byp_in));
        end
        idle_b();

        // Random traffic on dut_b
        for (int k = 0; k < 300; k++) begin
            rand_b();
            step();
        end

        // Asynchronous reset while beats are presented on both DUTs
        bus_a.in_valid = 1; bus_a.in_data = 8'($urandom); bus_a.chk_en = 1;
        bus_b.in_valid = 1; bus_b.in_data = 16'($urandom); bus_b.scr_rst = '0;
        bus_b.in_hold = '0; bus_b.chk_clr = 0;
        step();
        bus_a.in_data = 8'($urandom); bus_b.in_data = 16'($urandom);
        #2 rst = 1'b1;
        #1;
        check("a_rst_valid", 32'(bus_a.out_valid), 32'd0);
        check("a_rst_data",  32'(bus_a.out_data),  32'd0);
        check("b_rst_valid", 32'(bus_b.out_valid), 32'd0);
        check("b_rst_data",  32'(bus_b.out_data),  32'd0);
        check("a_rst_cnt",   32'(bus_a.err_cnt),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_a();
        bus_a.in_valid = 1; bus_a.in_data = 8'h00;
        bus_b.in_valid = 1; bus_b.in_data = 16'($urandom); bus_b.bypass = 0;
        step(); check("a_post_rst", 32'(bus_a.out_data), 32'hC8);
        bus_a.in_data = 8'h00;
        step(); check("a_post_rst2", 32'(bus_a.out_data), 32'h7A);
        idle_a();
        idle_b();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
